// File: rtl/mesh_pkg.sv
// Shared types and helpers for the mesh terminal receive stage: packet field
// offsets, the receive FSM state type and the destination match function.
package mesh_pkg;

  localparam int unsigned pckg_sz_dflt = 40;

  localparam int unsigned hdr_w   = 8;
  localparam int unsigned row_w   = 4;
  localparam int unsigned col_w   = 4;
  localparam int unsigned route_w = hdr_w + row_w + col_w;

  localparam int unsigned hdr_msb  = pckg_sz_dflt - 1;
  localparam int unsigned hdr_lsb  = pckg_sz_dflt - 8;
  localparam int unsigned row_msb  = pckg_sz_dflt - 9;
  localparam int unsigned row_lsb  = pckg_sz_dflt - 12;
  localparam int unsigned col_msb  = pckg_sz_dflt - 13;
  localparam int unsigned col_lsb  = pckg_sz_dflt - 16;
  localparam int unsigned mode_bit = pckg_sz_dflt - 17;
  localparam int unsigned pay_msb  = pckg_sz_dflt - 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } rx_state_e;

  // Routing prefix of a packet: the top route_w bits, header first.
  typedef struct packed {
    logic [7:0] hdr;
    logic [3:0] row;
    logic [3:0] col;
  } route_t;

  function automatic logic pkt_dest_match(input route_t     pkt,
                                          input logic [3:0] row,
                                          input logic [3:0] col,
                                          input logic [7:0] bdcst);
    logic hit;
    hit = ((pkt.row == row) && (pkt.col == col)) || (pkt.hdr == bdcst);
    return hit;
  endfunction

endpackage

// File: rtl/mesh_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on
// rd_data whenever empty is low. Simultaneous read and write are allowed.
module mesh_rx_fifo #(
  parameter int width = 40,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem_r [depth];
  logic [aw-1:0]    wr_ptr_r;
  logic [aw-1:0]    rd_ptr_r;
  logic [cw-1:0]    count_r;
  logic             rd_ok_s;
  logic             wr_ok_s;

  assign empty   = (count_r == {cw{1'b0}});
  assign full    = (count_r == cw'(depth));
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // A write into a full FIFO is only taken when the head leaves the same cycle.
  always_comb begin
    rd_ok_s = rd_en && !empty;
    wr_ok_s = wr_en && (!full || rd_ok_s);
  end

  // Storage array; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i] <= {width{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {aw{1'b0}};
      rd_ptr_r <= {aw{1'b0}};
    end else begin
      wr_ptr_r <= wr_ok_s ? (wr_ptr_r + aw'(1)) : wr_ptr_r;
      rd_ptr_r <= rd_ok_s ? (rd_ptr_r + aw'(1)) : rd_ptr_r;
    end
  end

  // Occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {cw{1'b0}};
    end else begin
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + cw'(1);
        2'b01:   count_r <= count_r - cw'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_rx.sv
// Terminal receive stage: drains one mesh output port, keeps packets addressed
// to this terminal (or broadcast) in a FIFO and counts accepted/dropped ones.
module mesh_term_rx
  import mesh_pkg::*;
#(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF,
  parameter logic [3:0] ROW_ID     = 4'd0,
  parameter logic [3:0] COL_ID     = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        drop_cnt,
  output logic               misroute
);

  localparam int cnt_w     = $clog2(fifo_depth) + 1;
  localparam int route_lsb = pckg_sz - int'(route_w);

  rx_state_e          state_r;
  rx_state_e          state_s;
  logic               pop_r;
  logic               misroute_r;
  logic [15:0]        pkt_cnt_r;
  logic [15:0]        drop_cnt_r;
  route_t             route_s;
  logic               match_s;
  logic               take_s;
  logic               drop_s;
  logic               fifo_wr_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [cnt_w-1:0]   fifo_cnt_s;

  assign route_s = route_t'(data_out[pckg_sz-1:route_lsb]);

  // Destination check and the capture decision for the POP cycle.
  always_comb begin
    match_s   = pkt_dest_match(route_s, ROW_ID, COL_ID, bdcst);
    take_s    = (state_r == POP) && match_s;
    drop_s    = (state_r == POP) && !match_s;
    fifo_wr_s = take_s && !fifo_full_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; SETTLE gives the mesh a cycle to refresh pndng/data_out.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pndng && (fifo_cnt_s < cnt_w'(fifo_depth))) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP:     state_s = SETTLE;
      SETTLE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered strobes: pop is high exactly while in POP, misroute the cycle after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_r      <= 1'b0;
      misroute_r <= 1'b0;
    end else begin
      pop_r      <= (state_s == POP);
      misroute_r <= drop_s;
    end
  end

  // Saturating accept/drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_r  <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (fifo_wr_s && (pkt_cnt_r != 16'hFFFF)) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  mesh_rx_fifo #(
    .width (pckg_sz),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr_s),
    .wr_data (data_out),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_cnt_s)
  );

  assign pop      = pop_r;
  assign misroute = misroute_r;
  assign rx_valid = !fifo_empty_s;
  assign pkt_cnt  = pkt_cnt_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Scoreboard bench for mesh_term_rx (ROW_ID=0, COL_ID=2, depth 4) with a
// behavioural mesh output port model.
module tb_mesh_term_rx;

  logic        clk;
  logic        reset;
  logic        pndng;
  logic [39:0] data_out;
  logic        pop;
  logic        rx_valid;
  logic [39:0] rx_data;
  logic        rx_ready;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        misroute;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int mis_cnt = 0;
  logic pop_prev = 1'b0;
  int pop_times[$];
  logic [39:0] mesh_q[$];
  logic [39:0] exp_q[$];

  mesh_term_rx #(
    .pckg_sz    (40),
    .fifo_depth (4),
    .bdcst      (8'hFF),
    .ROW_ID     (4'd0),
    .COL_ID     (4'd2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .data_out (data_out),
    .pop      (pop),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .misroute (misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] mk(input logic [7:0] h, input logic [3:0] r,
                                     input logic [3:0] c, input logic m,
                                     input logic [22:0] p);
    return {h, r, c, m, p};
  endfunction

  task automatic push(input logic [39:0] pkt, input logic accept);
    mesh_q.push_back(pkt);
    if (accept) exp_q.push_back(pkt);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mesh_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Mesh output port: head advances just after the edge that ended a pop cycle.
  initial begin
    logic pop_seen;
    pndng = 1'b0;
    data_out = 40'd0;
    forever begin
      @(negedge clk);
      pop_seen = pop;
      @(posedge clk);
      #1;
      if (pop_seen && mesh_q.size() != 0) void'(mesh_q.pop_front());
      pndng = (mesh_q.size() != 0);
      data_out = (mesh_q.size() != 0) ? mesh_q[0] : 40'd0;
    end
  end

  // Scoreboard monitor: compare the FIFO head whenever it is presented.
  always @(negedge clk) begin
    if (reset && rx_valid) begin
      if (exp_q.size() == 0) chk("rx_valid_unexpected", rx_valid, 1'b0);
      else if (rx_ready) chk("rx_data", rx_data, exp_q.pop_front());
      else chk("rx_hold", rx_data, exp_q[0]);
    end
  end

  // Strobe monitor: pop spacing and pulse counts.
  always @(negedge clk) begin
    if (pop) begin
      chk("pop_not_consecutive", pop_prev, 1'b0);
      pop_cnt++;
      pop_times.push_back(cyc);
    end
    if (misroute) mis_cnt++;
    pop_prev = pop;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pb, mb, tb0;
    logic [39:0] p1;
    reset = 1'b0;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pop", pop, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 40'd0);
    chk("rst_pkt_cnt", pkt_cnt, 16'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    chk("rst_misroute", misroute, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Matching packet: latency and counters.
    pb = pop_cnt;
    @(negedge clk);
    p1 = mk(8'h00, 4'd0, 4'd2, 1'b0, 23'd1);
    push(p1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("t1_pop_early", pop, 1'b0);
    @(negedge clk);
    chk("t1_pop", pop, 1'b1);
    chk("t1_valid_early", rx_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", rx_valid, 1'b1);
    chk("t1_data", rx_data, p1);
    wait_drain(20);
    repeat (3) @(negedge clk);
    chk("t1_pkt_cnt", pkt_cnt, 16'd1);
    chk("t1_drop_cnt", drop_cnt, 16'd0);
    chk("t1_pops", pop_cnt - pb, 1);

    // Misrouted packet.
    do_reset();
    pb = pop_cnt;
    mb = mis_cnt;
    @(negedge clk);
    push(mk(8'h00, 4'd1, 4'd2, 1'b0, 23'd3), 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_misroute", mis_cnt - mb, 1);
    chk("t2_drop_cnt", drop_cnt, 16'd1);
    chk("t2_pkt_cnt", pkt_cnt, 16'd0);
    chk("t2_pops", pop_cnt - pb, 1);
    chk("t2_rx_valid", rx_valid, 1'b0);

    // Broadcast accepted; near-broadcast header with wrong dest dropped.
    do_reset();
    @(negedge clk);
    push(mk(8'hFF, 4'd5, 4'd7, 1'b1, 23'h5A5A5), 1'b1);
    push(mk(8'hFE, 4'd5, 4'd7, 1'b0, 23'h00042), 1'b0);
    wait_drain(20);
    repeat (10) @(negedge clk);
    chk("t3_pkt_cnt", pkt_cnt, 16'd1);
    chk("t3_drop_cnt", drop_cnt, 16'd1);

    // Backpressure: 6 packets, FIFO of 4.
    do_reset();
    pb = pop_cnt;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) push(mk(8'h00, 4'd0, 4'd2, i[0], 23'(i + 16)), 1'b1);
    repeat (30) @(negedge clk);
    chk("t4_pops_full", pop_cnt - pb, 4);
    chk("t4_pndng", pndng, 1'b1);
    chk("t4_pkt_cnt_full", pkt_cnt, 16'd4);
    chk("t4_rx_valid", rx_valid, 1'b1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    wait_drain(80);
    repeat (10) @(negedge clk);
    chk("t4_pkt_cnt", pkt_cnt, 16'd6);
    chk("t4_pops", pop_cnt - pb, 6);
    chk("t4_pndng_done", pndng, 1'b0);

    // Continuous pndng: pop period is 3 cycles.
    do_reset();
    tb0 = pop_times.size();
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(mk(8'h00, 4'd0, 4'd2, 1'b0, 23'(i + 100)), 1'b1);
    wait_drain(60);
    chk("t5_pops", pop_times.size() - tb0, 5);
    for (int i = tb0 + 1; i < pop_times.size(); i++)
      chk("t5_pop_period", pop_times[i] - pop_times[i-1], 3);

    // Reset while in POP.
    do_reset();
    @(negedge clk);
    push(mk(8'h00, 4'd0, 4'd2, 1'b0, 23'd7), 1'b1);
    begin
      int n = 0;
      while (!pop && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_pop_seen", pop, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_pop_async", pop, 1'b0);
    mesh_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_pkt_cnt", pkt_cnt, 16'd0);
    chk("t6_drop_cnt", drop_cnt, 16'd0);
    chk("t6_rx_valid", rx_valid, 1'b0);
    chk("t6_rx_data", rx_data, 40'd0);
    chk("t6_pop", pop, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mesh_term_rx.md
# mesh_term_rx

Terminal receive stage attached to one output port of `mesh_gnrtr`. It drains packets from the mesh's per-terminal output (`pndng`/`data_out`/`pop`) and checks each packet's destination row/column against its own terminal ID. Accepted packets go into a small FIFO that presents a valid/ready stream to the local consumer. Misrouted packets are dropped, and the block keeps saturating accept and drop counters.

## Interface
- `pckg_sz`, 40: packet width in bits.
- `fifo_depth`, 4: receive FIFO entries; power of two, at least 2.
- `bdcst`, 8'hFF: header byte value that marks a broadcast.
- `ROW_ID`, 0: this terminal's row, 4 bits.
- `COL_ID`, 0: this terminal's column, 4 bits.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  in  1  mesh output holds a packet.
- `data_out`  in  pckg_sz  packet at the head of the mesh output.
- `pop`  out  1  one-cycle pop strobe to the mesh.
- `rx_valid`  out  1  FIFO head is valid.
- `rx_data`  out  pckg_sz  FIFO head data.
- `rx_ready`  in  1  consumer takes the head when `rx_valid && rx_ready`.
- `pkt_cnt`  out  16  accepted packets, saturating.
- `drop_cnt`  out  16  dropped packets, saturating.
- `misroute`  out  1  one-cycle pulse when a packet is dropped.

## Operation
- Packet fields:
  - header `[pckg_sz-1:pckg_sz-8]`
  - row `[pckg_sz-9:pckg_sz-12]`
  - col `[pckg_sz-13:pckg_sz-16]`
  - mode `[pckg_sz-17]`
  - payload `[pckg_sz-18:0]`
- Accept rule: `(row==ROW_ID && col==COL_ID) || header==bdcst`. Otherwise drop.
- FSM states: IDLE, POP, SETTLE.
  - IDLE → POP when `pndng && fifo_cnt < fifo_depth`. `fifo_cnt` is the registered count at the decision edge.
  - POP: `pop=1` for exactly one cycle. `data_out` is captured on this cycle's rising edge.
    - Accepted: the packet is written into the FIFO and `pkt_cnt` increments.
    - Rejected: no write, `drop_cnt` increments, `misroute=1` on the following cycle. The packet is discarded; it does not stall the mesh.
  - POP → SETTLE unconditionally.
  - SETTLE → IDLE unconditionally. This gives the mesh one cycle to update `pndng`/`data_out`.
- Mesh throughput: at most one pop every 3 cycles.
- FIFO: a read and a write in the same cycle are both legal, including when the FIFO is full or empty.
  - The FSM never pops while the FIFO is full, so overflow is impossible.
  - Reads from an empty FIFO are ignored.
- Counters: both saturate at 16'hFFFF and never wrap.
- Mode and payload are passed through unmodified.

## Timing
- Reset values (asserted asynchronously while `reset==0`):
  - state = IDLE; `pop=0`, `rx_valid=0`, `rx_data=0`, `pkt_cnt=0`, `drop_cnt=0`, `misroute=0`.
  - FIFO pointers and count cleared.
- Reset mid-operation:
  - `pop` drops immediately and any in-flight capture is lost.
  - The mesh must tolerate a pop strobe that is truncated by reset.
- Latency:
  - `pndng` rising in IDLE with space available → `pop` high on the next cycle.
  - Accepted packet → `rx_valid` high one cycle after the POP edge; `rx_data` is valid on that same cycle.
- Handshake:
  - `rx_data` and `rx_valid` stay stable until `rx_ready` is seen.
  - `rx_ready` may be held high permanently.
  - `pop` is never high on two consecutive cycles.
- `pndng` deasserting while the FSM is in POP: the capture still happens, because `pop` was issued on valid data.

## Structure
- Package `mesh_pkg` holds:
  - field offset localparams derived from `pckg_sz`;
  - `typedef enum {IDLE, POP, SETTLE} rx_state_e`;
  - function `pkt_dest_match(pkt, row, col, bdcst)`.
- Sub-module `mesh_rx_fifo` (params `width`, `depth`): synchronous, first-word-fall-through, with `full`, `empty` and `count` outputs.
- Top level holds the FSM, the match check, the counters and the `misroute` pulse.

## Test plan
- Reset, then a packet with row=0, col=2, payload=1 on a `COL_ID=2` instance → one `pop` pulse; `rx_data` equals the packet after 2 cycles; `pkt_cnt=1`.
- Packet with row=1, col=2 on a `ROW_ID=0`, `COL_ID=2` instance → `pop` pulse, `misroute` pulse, `drop_cnt=1`, `rx_valid` stays 0.
- Header 8'hFF with a non-matching row/col → accepted, `pkt_cnt=1`.
- `rx_ready=0` and 6 back-to-back matching packets with `fifo_depth=4` → exactly 4 pops, `pndng` remains high. Raising `rx_ready` drains all 6 in order.
- `pndng` held high with `rx_ready=1` → `pop` period is 3 cycles and never on consecutive cycles.
- `reset` asserted while in POP → `pop=0` in the same cycle; counters and FIFO are zero after release.
